// File: rtl/ssd_scan_controller.sv
// Time-multiplexed scan controller for common-anode seven-segment digits, LSD first.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading-zero digits above digit 0).
module ssd_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIV_COUNT    = 50000,
    parameter int GUARD_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic                    data_valid,
    output logic                    data_ready,
    input  logic                    display_en,
    output logic [3:0]              digit_nibble,
    output logic                    digit_blank,
    output logic [NUM_DIGITS-1:0]   anode_n,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW    = 4 * NUM_DIGITS;
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DIV_COUNT - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GUARD,
        ST_DRIVE
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DW-1:0]           shadow_q, shadow_d;
    logic [DW-1:0]           pend_q, pend_d;
    logic                    ready_q, ready_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic                    blank_q, blank_d;
    logic [3:0]              nibble_q, nibble_d;
    logic                    frame_done_q, frame_done_d;
    logic                    lz;

    // Scan sequencing: IDLE -> GUARD -> DRIVE -> GUARD ... one digit per GUARD/DRIVE pair.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + CNT_W'(1);
        if (!display_en) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_GUARD;
                    cnt_d   = '0;
                end
                ST_GUARD: begin
                    if (cnt_q == GUARD_LAST) begin
                        state_d = ST_DRIVE;
                        cnt_d   = '0;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == DRIVE_LAST) begin
                        state_d = ST_GUARD;
                        cnt_d   = '0;
                        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Two-stage buffer; ready_q doubles as the "pending empty" flag.
    always_comb begin
        pend_d   = pend_q;
        ready_d  = ready_q;
        shadow_d = shadow_q;
        if (data_valid && ready_q) begin
            pend_d  = data_in;
            ready_d = 1'b0;
        end
        if (!ready_q && (frame_done_q || state_q == ST_IDLE)) begin
            shadow_d = pend_q;
            ready_d  = 1'b1;
        end
    end

    // NOTE: outputs are decoded from next-state values so the registered outputs line up with state_q.
    always_comb begin
        lz = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        lz = (idx_d != '0);
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k >= int'(idx_d) && shadow_d[4*k +: 4] != 4'h0) lz = 1'b0;
        end
`endif
        anode_d      = '1;
        blank_d      = 1'b1;
        nibble_d     = shadow_d[4*int'(idx_d) +: 4];
        frame_done_d = 1'b0;
        if (state_d == ST_DRIVE) begin
            if (!lz) begin
                anode_d = ~(NUM_DIGITS'(1) << idx_d);
                blank_d = 1'b0;
            end
            frame_done_d = (idx_d == IDX_LAST) && (cnt_d == DRIVE_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            shadow_q     <= '0;
            pend_q       <= '0;
            ready_q      <= 1'b1;
            anode_q      <= '1;
            blank_q      <= 1'b1;
            nibble_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            pend_q       <= pend_d;
            ready_q      <= ready_d;
            anode_q      <= anode_d;
            blank_q      <= blank_d;
            nibble_q     <= nibble_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign data_ready   = ready_q;
    assign anode_n      = anode_q;
    assign digit_blank  = blank_q;
    assign digit_nibble = nibble_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Directed bench for ssd_scan_controller with NUM_DIGITS=4, DIV_COUNT=4, GUARD_CYCLES=1.
module tb_ssd_scan_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data_in;
    logic        data_valid;
    logic        data_ready;
    logic        display_en;
    logic [3:0]  digit_nibble;
    logic        digit_blank;
    logic [3:0]  anode_n;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;

    ssd_scan_controller #(
        .NUM_DIGITS  (4),
        .DIV_COUNT   (4),
        .GUARD_CYCLES(1),
        .CNT_W       (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .display_en  (display_en),
        .digit_nibble(digit_nibble),
        .digit_blank (digit_blank),
        .anode_n     (anode_n),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {anode_n, blank, nibble, frame_done} at frame position p (0..19):
    // each digit is one guard cycle followed by four drive cycles.
    function automatic logic [9:0] exp_vec(input int p, input logic [15:0] w);
        int d;
        int s;
        logic [3:0] an;
        logic       bl;
        logic       lzb;
        d   = p / 5;
        s   = p % 5;
        lzb = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        lzb = (d != 0) && ((w >> (4*d)) == 16'h0);
`endif
        an = 4'hF;
        bl = 1'b1;
        if (s != 0 && !lzb) begin
            an = ~(4'b0001 << d);
            bl = 1'b0;
        end
        return {an, bl, w[4*d +: 4], (p == 19)};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; display_en = 1'b0; data_valid = 1'b0; data_in = '0;
        repeat (2) @(posedge clk);
        #3;
        checks++;
        if ({anode_n, digit_blank, digit_nibble, data_ready, frame_done} !== {4'hF, 1'b1, 4'h0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_values got=%b exp=%b", {anode_n, digit_blank, digit_nibble, data_ready, frame_done},
                     {4'hF, 1'b1, 4'h0, 1'b1, 1'b0});
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({anode_n, digit_blank, data_ready, frame_done} !== {4'hF, 1'b1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL idle_after_reset got=%b exp=%b", {anode_n, digit_blank, data_ready, frame_done}, 7'b1111110);
        end
    endtask

    task automatic test_frame();
        int n;
        data_in = 16'h1A2B; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        checks++;
        if (data_ready !== 1'b0) begin
            failures++; $display("FAIL accept_ready got=%b exp=0", data_ready);
        end
        tick();
        checks++;
        if (data_ready !== 1'b1) begin
            failures++; $display("FAIL idle_transfer_ready got=%b exp=1", data_ready);
        end
        display_en = 1'b1;
        for (int p = 0; p < 20; p++) begin
            tick();
            checks++;
            if ({anode_n, digit_blank, digit_nibble, frame_done} !== exp_vec(p, 16'h1A2B)) begin
                failures++;
                $display("FAIL frame_1a2b p=%0d got=%b exp=%b", p, {anode_n, digit_blank, digit_nibble, frame_done},
                         exp_vec(p, 16'h1A2B));
            end
        end
        n = 0;
        do begin
            tick();
            n++;
        end while (frame_done !== 1'b1 && n < 100);
        checks++;
        if (n != 20) begin
            failures++; $display("FAIL frame_period got=%0d exp=20", n);
        end
    endtask

    task automatic test_midframe_load();
        for (int p = 0; p < 20; p++) begin
            if (p == 1) begin data_in = 16'h00F0; data_valid = 1'b1; end
            if (p == 2) data_valid = 1'b0;
            tick();
            checks++;
            if ({anode_n, digit_blank, digit_nibble, frame_done, data_ready} !== {exp_vec(p, 16'h1A2B), (p < 1)}) begin
                failures++;
                $display("FAIL midframe_old p=%0d got=%b exp=%b", p,
                         {anode_n, digit_blank, digit_nibble, frame_done, data_ready}, {exp_vec(p, 16'h1A2B), (p < 1)});
            end
        end
        for (int p = 0; p < 20; p++) begin
            tick();
            checks++;
            if ({anode_n, digit_blank, digit_nibble, frame_done, data_ready} !== {exp_vec(p, 16'h00F0), 1'b1}) begin
                failures++;
                $display("FAIL midframe_new p=%0d got=%b exp=%b", p,
                         {anode_n, digit_blank, digit_nibble, frame_done, data_ready}, {exp_vec(p, 16'h00F0), 1'b1});
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int p = 0; p < 20; p++) begin
            if (p == 0) begin data_in = 16'h1234; data_valid = 1'b1; end
            if (p == 1) data_in = 16'h5678;
            tick();
            checks++;
            if ({anode_n, digit_blank, digit_nibble, frame_done, data_ready} !== {exp_vec(p, 16'h00F0), 1'b0}) begin
                failures++;
                $display("FAIL b2b_hold p=%0d got=%b exp=%b", p,
                         {anode_n, digit_blank, digit_nibble, frame_done, data_ready}, {exp_vec(p, 16'h00F0), 1'b0});
            end
        end
        for (int p = 0; p < 20; p++) begin
            if (p == 2) data_valid = 1'b0;
            tick();
            checks++;
            if ({anode_n, digit_blank, digit_nibble, frame_done, data_ready} !== {exp_vec(p, 16'h1234), (p < 1)}) begin
                failures++;
                $display("FAIL b2b_first p=%0d got=%b exp=%b", p,
                         {anode_n, digit_blank, digit_nibble, frame_done, data_ready}, {exp_vec(p, 16'h1234), (p < 1)});
            end
        end
        for (int p = 0; p < 20; p++) begin
            tick();
            checks++;
            if ({anode_n, digit_blank, digit_nibble, frame_done, data_ready} !== {exp_vec(p, 16'h5678), 1'b1}) begin
                failures++;
                $display("FAIL b2b_second p=%0d got=%b exp=%b", p,
                         {anode_n, digit_blank, digit_nibble, frame_done, data_ready}, {exp_vec(p, 16'h5678), 1'b1});
            end
        end
    endtask

    task automatic test_disable();
        for (int p = 0; p <= 12; p++) begin
            tick();
            checks++;
            if ({anode_n, digit_blank, digit_nibble, frame_done} !== exp_vec(p, 16'h5678)) begin
                failures++;
                $display("FAIL dis_pre p=%0d got=%b exp=%b", p, {anode_n, digit_blank, digit_nibble, frame_done},
                         exp_vec(p, 16'h5678));
            end
        end
        display_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({anode_n, digit_blank, frame_done} !== 6'b111110) begin
                failures++;
                $display("FAIL dis_dark i=%0d got=%b exp=%b", i, {anode_n, digit_blank, frame_done}, 6'b111110);
            end
        end
        display_en = 1'b1;
        for (int p = 0; p < 20; p++) begin
            tick();
            checks++;
            if ({anode_n, digit_blank, digit_nibble, frame_done} !== exp_vec(p, 16'h5678)) begin
                failures++;
                $display("FAIL dis_restart p=%0d got=%b exp=%b", p, {anode_n, digit_blank, digit_nibble, frame_done},
                         exp_vec(p, 16'h5678));
            end
        end
    endtask

    task automatic test_leading_zero();
        for (int p = 0; p < 20; p++) begin
            if (p == 0) begin data_in = 16'h0005; data_valid = 1'b1; end
            if (p == 1) data_valid = 1'b0;
            tick();
            checks++;
            if ({anode_n, digit_blank, digit_nibble, frame_done} !== exp_vec(p, 16'h5678)) begin
                failures++;
                $display("FAIL lz_old p=%0d got=%b exp=%b", p, {anode_n, digit_blank, digit_nibble, frame_done},
                         exp_vec(p, 16'h5678));
            end
        end
        for (int p = 0; p < 20; p++) begin
            tick();
            checks++;
            if ({anode_n, digit_blank, digit_nibble, frame_done} !== exp_vec(p, 16'h0005)) begin
                failures++;
                $display("FAIL lz_new p=%0d got=%b exp=%b", p, {anode_n, digit_blank, digit_nibble, frame_done},
                         exp_vec(p, 16'h0005));
            end
        end
    endtask

    task automatic test_async_reset();
        repeat (7) tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({anode_n, digit_blank, digit_nibble, data_ready, frame_done} !== {4'hF, 1'b1, 4'h0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL async_reset got=%b exp=%b", {anode_n, digit_blank, digit_nibble, data_ready, frame_done},
                     {4'hF, 1'b1, 4'h0, 1'b1, 1'b0});
        end
        tick();
        rst_n = 1'b1;
        for (int p = 0; p < 20; p++) begin
            tick();
            checks++;
            if ({anode_n, digit_blank, digit_nibble, frame_done} !== exp_vec(p, 16'h0000)) begin
                failures++;
                $display("FAIL post_reset_shadow p=%0d got=%b exp=%b", p, {anode_n, digit_blank, digit_nibble, frame_done},
                         exp_vec(p, 16'h0000));
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_midframe_load();
        test_back_to_back();
        test_disable();
        test_leading_zero();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
